parity_rx: RTL

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/parity_rx.sv
// parity_rx: serial frame receiver with parity and stop-bit checking.
// A frame is one start bit (0), 8 data bits LSB first, one parity bit and
// one stop bit (1). One bit is consumed per cycle with rx_valid=1; cycles
// with rx_valid=0 hold all state.
//
// Parameters:
//   ODD_PARITY  0 = even parity, 1 = odd parity
// Optional feature macro:
//   PARITY_RX_ERR_CNT_EN  defined: saturating count of errored frames on
//                         err_count; undefined: err_count tied to 8'h00
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   rx_bit      serial data bit, sampled when rx_valid=1
//   rx_valid    bit strobe
//   data_out    last received data byte, held until the next frame
//   data_valid  one-cycle pulse, the cycle after the stop strobe
//   parity_err  parity mismatch, valid with data_valid
//   frame_err   stop bit was 0, valid with data_valid
//   busy        high while a frame is in progress
//   err_count   errored-frame counter (see macro above)
module parity_rx #(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ECNT_W = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              stop_take_c;
  logic              perr_c;
  logic              ferr_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; transitions only happen on strobe cycles
  always_comb begin
    state_next  = state;
    stop_take_c = 1'b0;
    if (rx_valid) begin
      case (state)
        S_IDLE:   if (!rx_bit) state_next = S_DATA;
        S_DATA:   if (count == CNT_W'(DATA_W - 1)) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          state_next  = S_IDLE;
          stop_take_c = 1'b1;
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Frame checks evaluated against the stop strobe currently being taken
  assign perr_c = par_bit != ((^shreg) ^ ODD_PARITY);
  assign ferr_c = ~rx_bit;

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= stop_take_c;
      parity_err <= stop_take_c & perr_c;
      frame_err  <= stop_take_c & ferr_c;
      busy       <= state_next != S_IDLE;
      if (stop_take_c) data_out <= shreg;
      if (rx_valid) begin
        case (state)
          S_IDLE: count <= '0;
          S_DATA: begin
            shreg[count] <= rx_bit;
            count        <= count + CNT_W'(1);
          end
          S_PARITY: par_bit <= rx_bit;
          default: ;
        endcase
      end
    end
  end

`ifdef PARITY_RX_ERR_CNT_EN
  // Counts in step with the data_valid pulse it belongs to; sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (stop_take_c && (perr_c || ferr_c) && (err_count != {ECNT_W{1'b1}})) begin
      err_count <= err_count + ECNT_W'(1);
    end
  end
`else
  assign err_count = ECNT_W'(0);
`endif

endmodule
